// File: rtl/prgmem_loader_pkg.sv
// Shared brainhack definitions: program memory, tape and stack width defaults,
// plus the program loader state encoding and terminator default.
// The optional checksum feature of the loader is enabled by PRGMEM_LOADER_CHECKSUM_EN.

`ifndef BH_PRGMEM_ADDR_WIDTH
`define BH_PRGMEM_ADDR_WIDTH 8
`endif

`ifndef BH_INSTR_WIDTH
`define BH_INSTR_WIDTH 8
`endif

`ifndef BH_TAPE_ADDR_WIDTH
`define BH_TAPE_ADDR_WIDTH 15
`endif

`ifndef BH_STACK_DEPTH_WIDTH
`define BH_STACK_DEPTH_WIDTH 5
`endif

package prgmem_loader_pkg;

    localparam int PRGMEM_ADDR_WIDTH = `BH_PRGMEM_ADDR_WIDTH;
    localparam int INSTR_WIDTH       = `BH_INSTR_WIDTH;

    // Terminator defaults to an all-zero instruction word of whatever width.
    localparam logic END_WORD_FILL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TERM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

endpackage

// File: rtl/prgmem_loader_if.sv
// Program word stream into the loader: valid/data/last from the source,
// ready back from the loader. Carries i_checksum when PRGMEM_LOADER_CHECKSUM_EN
// is defined.

interface prgmem_loader_if
    import prgmem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH
) ();

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_last;
    logic                  o_ready;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] i_checksum;
`endif

    modport master (
        output i_valid, i_data, i_last,
`ifdef PRGMEM_LOADER_CHECKSUM_EN
        output i_checksum,
`endif
        input  o_ready
    );

    modport slave (
        input  i_valid, i_data, i_last,
`ifdef PRGMEM_LOADER_CHECKSUM_EN
        input  i_checksum,
`endif
        output o_ready
    );

endinterface

// File: rtl/prgmem_addr_counter.sv
// Program memory write address counter: clear, increment modulo 2^ADDR_WIDTH,
// and a flag telling that the next increment wraps to zero.

module prgmem_addr_counter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_wrap
);

    // Reset and clear both return to address 0; increment wraps naturally.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            o_addr <= '0;
        end else if (i_inc) begin
            o_addr <= o_addr + ADDR_WIDTH'(1);
        end
    end

    assign o_wrap = &o_addr;

endmodule

// File: rtl/prgmem_loader.sv
// Program memory loader: streams program words into program memory while the
// CPU is held, then appends a terminator word. Optional running-XOR checksum
// check of the program is enabled by PRGMEM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | waiting for i_start, CPU free
// ST_LOAD  | accepting program words, CPU held
// ST_TERM  | writing the terminator after the last word
// ST_DONE  | load complete, CPU free, i_start reloads
// ST_ERROR | overflow or checksum mismatch, left only by reset

module prgmem_loader
    import prgmem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PRGMEM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = INSTR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] END_WORD   = {DATA_WIDTH{END_WORD_FILL}}
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    prgmem_loader_if.slave        bus,
    output logic                  o_prgmem_in,
    output logic [ADDR_WIDTH-1:0] o_prgmem_addr,
    output logic [DATA_WIDTH-1:0] o_prgmem_data,
    output logic                  o_cpu_hold,
    output logic                  o_done,
    output logic                  o_overflow,
`ifdef PRGMEM_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] o_checksum,
`endif
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_e         state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_wrap;
    logic                  xfer;
    logic                  start_ok;

    assign xfer     = (state == ST_LOAD) && bus.o_ready && bus.i_valid;
    assign start_ok = i_start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef PRGMEM_LOADER_CHECKSUM_EN
    logic sum_bad;
    assign sum_bad = (o_checksum ^ bus.i_data) != bus.i_checksum;
`endif

    prgmem_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (start_ok),
        .i_inc   (xfer),
        .o_addr  (addr),
        .o_wrap  (addr_wrap)
    );

    // Loader FSM with all outputs registered; the write strobe is a one-cycle pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            bus.o_ready   <= 1'b0;
            o_prgmem_in   <= 1'b0;
            o_prgmem_addr <= '0;
            o_prgmem_data <= '0;
            o_cpu_hold    <= 1'b0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_count       <= '0;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
            o_checksum    <= '0;
`endif
        end else begin
            o_prgmem_in <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state       <= ST_LOAD;
                        bus.o_ready <= 1'b1;
                        o_cpu_hold  <= 1'b1;
                        o_done      <= 1'b0;
                        o_overflow  <= 1'b0;
                        o_count     <= '0;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
                        o_checksum  <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        o_prgmem_in   <= 1'b1;
                        o_prgmem_addr <= addr;
                        o_prgmem_data <= bus.i_data;
                        o_count       <= (o_count == COUNT_MAX) ? o_count : o_count + 1'b1;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
                        o_checksum    <= o_checksum ^ bus.i_data;
`endif
                        if (bus.i_last) begin
                            bus.o_ready <= 1'b0;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
                            if (sum_bad) begin
                                state <= ST_ERROR;
                            end else
`endif
                            if (addr_wrap) begin
                                // No room left for the terminator.
                                state      <= ST_DONE;
                                o_done     <= 1'b1;
                                o_cpu_hold <= 1'b0;
                            end else begin
                                state <= ST_TERM;
                            end
                        end else if (addr_wrap) begin
                            state       <= ST_ERROR;
                            bus.o_ready <= 1'b0;
                            o_overflow  <= 1'b1;
                        end
                    end
                end
                ST_TERM: begin
                    o_prgmem_in   <= 1'b1;
                    o_prgmem_addr <= addr;
                    o_prgmem_data <= END_WORD;
                    state         <= ST_DONE;
                    o_done        <= 1'b1;
                    o_cpu_hold    <= 1'b0;
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prgmem_loader.sv
// Self-checking bench for prgmem_loader with a 4-bit address and 8-bit words.
// Checksum scenario is built when PRGMEM_LOADER_CHECKSUM_EN is defined.

module tb_prgmem_loader;

    localparam int             AW    = 4;
    localparam int             DW    = 8;
    localparam logic [DW-1:0]  END_W = 8'hE5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          o_prgmem_in;
    logic [AW-1:0] o_prgmem_addr;
    logic [DW-1:0] o_prgmem_data;
    logic          o_cpu_hold;
    logic          o_done;
    logic          o_overflow;
    logic [AW:0]   o_count;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    prgmem_loader_if #(.DATA_WIDTH(DW)) bus ();

    prgmem_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .END_WORD   (END_W)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .bus           (bus),
        .o_prgmem_in   (o_prgmem_in),
        .o_prgmem_addr (o_prgmem_addr),
        .o_prgmem_data (o_prgmem_data),
        .o_cpu_hold    (o_cpu_hold),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
`ifdef PRGMEM_LOADER_CHECKSUM_EN
        .o_checksum    (o_checksum),
`endif
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [AW-1:0] exp_addr;
    int            total = 0;
    int            bad   = 0;

    // Scoreboard: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        if (o_prgmem_in === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", o_prgmem_addr, o_prgmem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_prgmem_addr !== mon_e.a || o_prgmem_data !== mon_e.d) begin
                    bad++;
                    $display("FAIL write_payload: addr=%h data=%h, required addr=%h data=%h",
                             o_prgmem_addr, o_prgmem_data, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        total++;
        if ({o_prgmem_in, bus.o_ready, o_cpu_hold, o_done, o_overflow} !== 5'b0) begin
            bad++;
            $display("FAIL %s_flags: in/ready/hold/done/ovf=%b%b%b%b%b, required 00000",
                     tag, o_prgmem_in, bus.o_ready, o_cpu_hold, o_done, o_overflow);
        end
        total++;
        if (o_count !== '0 || o_prgmem_addr !== '0 || o_prgmem_data !== '0) begin
            bad++;
            $display("FAIL %s_regs: count=%0d addr=%h data=%h, required 0 0 0",
                     tag, o_count, o_prgmem_addr, o_prgmem_data);
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        exp_addr = '0;
        total++;
        if (bus.o_ready !== 1'b1 || o_cpu_hold !== 1'b1 || o_count !== '0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL start_load: ready=%b hold=%b count=%0d done=%b, required 1 1 0 0",
                     bus.o_ready, o_cpu_hold, o_count, o_done);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = last;
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        total++;
        if (o_prgmem_in !== 1'b1) begin
            bad++;
            $display("FAIL write_strobe: o_prgmem_in=%b after word %h, required 1", o_prgmem_in, d);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (o_prgmem_in !== 1'b0) begin
                bad++;
                $display("FAIL no_write: o_prgmem_in=%b in idle cycle %0d, required 0", o_prgmem_in, i);
            end
        end
    endtask

    task automatic expect_term(input int cnt);
        exp_q.push_back({exp_addr, END_W});
        total++;
        if (bus.o_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_drop: o_ready=%b after last word, required 0", bus.o_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (o_prgmem_in !== 1'b1 || o_done !== 1'b1 || o_cpu_hold !== 1'b0 || o_count !== cnt[AW:0]) begin
            bad++;
            $display("FAIL term_done: in=%b done=%b hold=%b count=%0d, required 1 1 0 %0d",
                     o_prgmem_in, o_done, o_cpu_hold, o_count, cnt);
        end
        idle_check(1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL term_pending: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        check_cleared("reset");
    endtask

    task automatic test_basic();
        start_load();
        send_word(8'h2B, 1'b0);
        send_word(8'h3E, 1'b0);
        send_word(8'h2D, 1'b1);
        expect_term(3);
    endtask

    task automatic test_gapped();
        start_load();
        for (int i = 0; i < 4; i++) begin
            send_word(8'h40 + 8'(i), (i == 3));
            if (i < 3) begin
                start = 1'b1;
                idle_check(1);
                start = 1'b0;
                idle_check(1);
            end
        end
        expect_term(4);
        bus.i_valid = 1'b1;
        idle_check(2);
        bus.i_valid = 1'b0;
        total++;
        if (o_count !== 5'd4 || o_done !== 1'b1) begin
            bad++;
            $display("FAIL valid_in_done: count=%0d done=%b, required 4 1", o_count, o_done);
        end
    endtask

    task automatic test_overflow();
        start_load();
        for (int i = 0; i < 16; i++) send_word(8'(i * 3 + 1), 1'b0);
        total++;
        if (o_overflow !== 1'b1 || o_cpu_hold !== 1'b1 || bus.o_ready !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL overflow: ovf=%b hold=%b ready=%b done=%b, required 1 1 0 0",
                     o_overflow, o_cpu_hold, bus.o_ready, o_done);
        end
        start       = 1'b1;
        bus.i_valid = 1'b1;
        idle_check(2);
        start       = 1'b0;
        bus.i_valid = 1'b0;
        total++;
        if (o_overflow !== 1'b1 || bus.o_ready !== 1'b0 || o_count !== 5'd16) begin
            bad++;
            $display("FAIL error_sticky: ovf=%b ready=%b count=%0d, required 1 0 16",
                     o_overflow, bus.o_ready, o_count);
        end
        do_reset();
        check_cleared("error_exit");
    endtask

    task automatic test_exact_fill();
        start_load();
        for (int i = 0; i < 16; i++) send_word(8'hA0 ^ 8'(i), (i == 15));
        total++;
        if (o_done !== 1'b1 || o_count !== 5'd16 || bus.o_ready !== 1'b0 || o_cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL exact_fill: done=%b count=%0d ready=%b hold=%b, required 1 16 0 0",
                     o_done, o_count, bus.o_ready, o_cpu_hold);
        end
        idle_check(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exact_pending: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h77;
        start       = 1'b1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        start       = 1'b0;
        bus.i_valid = 1'b0;
        check_cleared("midload_reset");
        idle_check(1);
        start_load();
        send_word(8'h5A, 1'b1);
        expect_term(1);
    endtask

`ifdef PRGMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        start_load();
        bus.i_checksum = 8'hFF;
        send_word(8'h0F, 1'b0);
        send_word(8'hF0, 1'b1);
        total++;
        if (o_checksum !== 8'hFF) begin
            bad++;
            $display("FAIL checksum_value: o_checksum=%h, required ff", o_checksum);
        end
        expect_term(2);
        start_load();
        total++;
        if (o_checksum !== 8'h00) begin
            bad++;
            $display("FAIL checksum_clear: o_checksum=%h, required 00", o_checksum);
        end
        bus.i_checksum = 8'h00;
        send_word(8'h0F, 1'b0);
        send_word(8'hF0, 1'b1);
        total++;
        if (o_overflow !== 1'b0 || o_done !== 1'b0 || o_cpu_hold !== 1'b1 || bus.o_ready !== 1'b0) begin
            bad++;
            $display("FAIL checksum_error: ovf=%b done=%b hold=%b ready=%b, required 0 0 1 0",
                     o_overflow, o_done, o_cpu_hold, bus.o_ready);
        end
        idle_check(2);
        total++;
        if (o_done !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL checksum_stuck: done=%b pending=%0d, required 0 0", o_done, exp_q.size());
        end
        do_reset();
    endtask
`endif

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
`ifdef PRGMEM_LOADER_CHECKSUM_EN
        bus.i_checksum = '0;
`endif
        exp_addr = '0;
        do_reset();
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_exact_fill();
        test_reset_midload();
`ifdef PRGMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prgmem_loader.md
PRGMEM_LOADER -- requirements
Module: prgmem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default `prgmem_addr_width, program memory address width.
REQ-002 Parameter DATA_WIDTH, default `instr_width, instruction word width.
REQ-003 Parameter END_WORD, default all-zero, terminator instruction written after the last program word.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 i_clock  in  1  rising-edge clock shared with the CPU and program memory.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_start  in  1  single-cycle request to begin a load.
REQ-008 i_valid  in  1  i_data/i_last valid.
REQ-009 i_data  in  DATA_WIDTH  program word.
REQ-010 i_last  in  1  marks the final program word.
REQ-011 o_ready  out  1  loader accepts a word this cycle.
REQ-012 o_prgmem_in  out  1  program memory write enable.
REQ-013 o_prgmem_addr  out  ADDR_WIDTH  write address.
REQ-014 o_prgmem_data  out  DATA_WIDTH  write data.
REQ-015 o_cpu_hold  out  1  keeps the CPU held off while memory is being rewritten.
REQ-016 o_done  out  1  load completed successfully.
REQ-017 o_overflow  out  1  program exceeded memory without i_last.
REQ-018 o_count  out  ADDR_WIDTH+1  number of program words written, excluding the terminator.

Function
REQ-019 States: IDLE, LOAD, TERM, DONE, ERROR.
REQ-020 IDLE: o_ready=0, o_cpu_hold=0; i_start moves to LOAD, clears o_count, o_done and o_overflow, and sets the address counter to 0.
REQ-021 LOAD: o_ready=1, o_cpu_hold=1; transfer occurs when i_valid and o_ready are both high at a rising edge.
REQ-022 A transfer drives o_prgmem_in=1 for exactly the following cycle, with o_prgmem_addr equal to the current address and o_prgmem_data equal to i_data (registered, 1-cycle latency); o_count and the address increment by 1.
REQ-023 Transfer with i_last=1: o_ready drops on the next cycle; go to TERM if address+1 does not wrap, otherwise go directly to DONE with no terminator written.
REQ-024 TERM: one cycle; write END_WORD at the next address, o_ready=0; then go to DONE.
REQ-025 DONE: o_done=1, o_cpu_hold=0, o_ready=0; i_start restarts at LOAD as in REQ-020.
REQ-026 Transfer with i_last=0 at address 2^ADDR_WIDTH-1: the word is written, then go to ERROR.
REQ-027 ERROR: o_overflow=1, o_cpu_hold=1, o_ready=0; only reset exits this state.
REQ-028 i_start is ignored in LOAD, TERM and ERROR; i_valid is ignored outside LOAD.
REQ-029 Address arithmetic is modulo 2^ADDR_WIDTH; o_count saturates at 2^ADDR_WIDTH.

Reset
REQ-030 i_reset=1 at a rising edge forces IDLE from any state, including mid-load, with all of the following cleared on the next cycle: o_prgmem_in, o_ready, o_cpu_hold, o_done, o_overflow, o_count, address, o_prgmem_addr and o_prgmem_data.
REQ-031 i_reset has priority over i_start and over any transfer presented in the same cycle.

Configuration
REQ-032 With PRGMEM_LOADER_CHECKSUM_EN defined: extra input i_checksum (DATA_WIDTH), sampled with the i_last transfer; output o_checksum (DATA_WIDTH) is the running XOR of accepted words and is cleared by i_start and reset; a mismatch at i_last goes to ERROR with o_overflow=0, and no terminator is written.
REQ-033 Without PRGMEM_LOADER_CHECKSUM_EN: neither port exists, and no checksum logic is present.

Structure
REQ-034 The loader state encoding, END_WORD default and width defaults live in the shared brainhack definitions header, alongside the existing prgmem/tape/stack width defines.
REQ-035 One sub-module, prgmem_addr_counter (load/clear/increment, wrap flag), is natural; everything else is flat.

Verification
REQ-036 Reset, then i_start, then words 0x2B,0x3E,0x2D with i_last on the third -> writes at addr 0,1,2 one cycle after each transfer, END_WORD at addr 3, then o_done=1 and o_count=3.
REQ-037 i_valid gapped (1 high, 2 low, repeating) for 4 words -> exactly 4 writes at consecutive addresses, no write in the gap cycles.
REQ-038 ADDR_WIDTH=4, 16 words with no i_last -> 16 writes, then ERROR with o_overflow=1, o_cpu_hold=1 and o_ready=0.
REQ-039 ADDR_WIDTH=4, i_last on the 16th word -> no terminator write, o_done=1, o_count=16.
REQ-040 i_reset asserted after the 2nd of 5 words -> next cycle IDLE, all outputs 0; a subsequent load starts again at addr 0.
REQ-041 CHECKSUM_EN: words 0x0F,0xF0 with i_checksum=0xFF -> o_done=1; repeating with i_checksum=0x00 -> ERROR with o_overflow=0.
